// File: rtl/mux_scan_pkg.sv
// Shared types and channel-search helpers for the 4-channel MUX scanner.
// Channel index i selects MUX input i+1 through {SELECTOR_1, SELECTOR_2}.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    typedef logic [1:0] ch_idx_t;

    localparam ch_idx_t CH_IN1 = 2'b00;
    localparam ch_idx_t CH_IN2 = 2'b01;
    localparam ch_idx_t CH_IN3 = 2'b10;
    localparam ch_idx_t CH_IN4 = 2'b11;

    typedef struct packed {
        logic    found;
        ch_idx_t idx;
    } ch_sel_t;

    // Lowest enabled channel strictly above idx; idx is returned unchanged if none.
    function automatic ch_sel_t next_enabled(input logic [3:0] mask, input ch_idx_t idx);
        ch_sel_t r;
        r.found = 1'b0;
        r.idx   = idx;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i > int'(idx))) begin
                r.found = 1'b1;
                r.idx   = ch_idx_t'(i);
            end
        end
        return r;
    endfunction

    function automatic ch_sel_t first_enabled(input logic [3:0] mask);
        ch_sel_t r;
        if (mask[0]) begin
            r.found = 1'b1;
            r.idx   = CH_IN1;
        end else begin
            r = next_enabled(mask, CH_IN1);
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_majority_sampler.sv
// Counts MUX_OUT ones across a dwell window and produces the majority vote.
// The vote includes the current-cycle input so it is valid on the final sample cycle.
module mux_majority_sampler #(
    parameter int DWELL_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic vote
);

    localparam int ONES_W = $clog2(DWELL_CYCLES + 1);
    localparam int SUM_W  = ONES_W + 2;

    logic [ONES_W-1:0] ones;
    logic [SUM_W-1:0]  total;

    // Strict majority: a tie resolves to 0.
    function automatic logic majority(input logic [SUM_W-1:0] n);
        return {n, 1'b0} > (SUM_W + 1)'(DWELL_CYCLES);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ones <= '0;
        end else if (en) begin
            ones <= ones + ONES_W'(din);
        end
    end

    always_comb begin
        total = SUM_W'(ones) + SUM_W'(din);
        vote  = majority(total);
    end

endmodule

// File: rtl/mux_channel_scanner.sv
// Sequences the MUX selectors through enabled channels, settles, samples,
// majority-votes each channel and assembles a 4-bit frame per scan.
module mux_channel_scanner
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int DWELL_CYCLES  = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       CONTINUOUS,
    input  logic [3:0] CHANNEL_MASK,
    input  logic       MUX_OUT,
    output logic       SELECTOR_1,
    output logic       SELECTOR_2,
    output logic       SAMPLE_VALID,
    output logic [1:0] SAMPLE_CHANNEL,
    output logic       SAMPLE_BIT,
    output logic [3:0] FRAME,
    output logic       FRAME_VALID,
    output logic       BUSY
);

    localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       mask_q;
    ch_idx_t          sel_q;
    logic [3:0]       frame_q;
    logic             sample_valid_q;
    ch_idx_t          sample_channel_q;
    logic             sample_bit_q;
    logic             frame_valid_q;
    logic             busy_q;

    ch_sel_t          next_ch;
    ch_sel_t          start_ch;
    logic [3:0]       frame_upd;
    logic             vote;

    mux_majority_sampler #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_sampler (
        .clk  (CLK),
        .rst_n(RST_N),
        .clr  (state != SAMPLE),
        .en   (state == SAMPLE),
        .din  (MUX_OUT),
        .vote (vote)
    );

    // Disabled channels are zeroed on every write so a mask change between
    // continuous frames cannot leave stale bits behind.
    always_comb begin
        next_ch          = next_enabled(mask_q, sel_q);
        start_ch         = first_enabled(CHANNEL_MASK);
        frame_upd        = frame_q & mask_q;
        frame_upd[sel_q] = vote;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state            <= IDLE;
            cnt              <= '0;
            mask_q           <= '0;
            sel_q            <= CH_IN1;
            frame_q          <= '0;
            sample_valid_q   <= 1'b0;
            sample_channel_q <= CH_IN1;
            sample_bit_q     <= 1'b0;
            frame_valid_q    <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            frame_valid_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (START && start_ch.found) begin
                        mask_q  <= CHANNEL_MASK;
                        frame_q <= '0;
                        sel_q   <= start_ch.idx;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (cnt == DWELL_LAST) begin
                        cnt              <= '0;
                        sample_valid_q   <= 1'b1;
                        sample_channel_q <= sel_q;
                        sample_bit_q     <= vote;
                        frame_q          <= frame_upd;
                        if (next_ch.found) begin
                            sel_q <= next_ch.idx;
                            state <= SETTLE;
                        end else begin
                            frame_valid_q <= 1'b1;
                            if (CONTINUOUS && start_ch.found) begin
                                mask_q <= CHANNEL_MASK;
                                sel_q  <= start_ch.idx;
                                state  <= SETTLE;
                            end else begin
                                if (CONTINUOUS) begin
                                    mask_q <= CHANNEL_MASK;
                                end
                                busy_q <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign SELECTOR_1     = sel_q[1];
    assign SELECTOR_2     = sel_q[0];
    assign SAMPLE_VALID   = sample_valid_q;
    assign SAMPLE_CHANNEL = sample_channel_q;
    assign SAMPLE_BIT     = sample_bit_q;
    assign FRAME          = frame_q;
    assign FRAME_VALID    = frame_valid_q;
    assign BUSY           = busy_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed bench for mux_channel_scanner: table-driven single-shot scans,
// vote patterns, continuous mode, reset and ignored-START sequences.
module tb_mux_channel_scanner;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       START;
    logic       CONTINUOUS;
    logic [3:0] CHANNEL_MASK;
    logic       MUX_OUT;
    logic       SELECTOR_1;
    logic       SELECTOR_2;
    logic       SAMPLE_VALID;
    logic [1:0] SAMPLE_CHANNEL;
    logic       SAMPLE_BIT;
    logic [3:0] FRAME;
    logic       FRAME_VALID;
    logic       BUSY;

    // Behavioural MUX: input i drives OUTPUT_1 when the selectors encode i.
    logic [3:0] mux_in;
    logic       ovr_en;
    logic       ovr_val;
    assign MUX_OUT = ovr_en ? ovr_val : mux_in[{SELECTOR_1, SELECTOR_2}];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    mux_channel_scanner dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .START         (START),
        .CONTINUOUS    (CONTINUOUS),
        .CHANNEL_MASK  (CHANNEL_MASK),
        .MUX_OUT       (MUX_OUT),
        .SELECTOR_1    (SELECTOR_1),
        .SELECTOR_2    (SELECTOR_2),
        .SAMPLE_VALID  (SAMPLE_VALID),
        .SAMPLE_CHANNEL(SAMPLE_CHANNEL),
        .SAMPLE_BIT    (SAMPLE_BIT),
        .FRAME         (FRAME),
        .FRAME_VALID   (FRAME_VALID),
        .BUSY          (BUSY)
    );

    typedef struct {
        logic [3:0] mask;
        logic [3:0] ins;
        logic [3:0] exp_frame;
        int         exp_last;
    } scan_vec_t;

    typedef struct {
        logic [3:0] pat;
        logic       exp_bit;
    } vote_vec_t;

    scan_vec_t scans[5];
    vote_vec_t votes[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},   int'({SELECTOR_1, SELECTOR_2}), 0);
        check({tag, "_sv"},    int'(SAMPLE_VALID), 0);
        check({tag, "_chan"},  int'(SAMPLE_CHANNEL), 0);
        check({tag, "_bit"},   int'(SAMPLE_BIT), 0);
        check({tag, "_frame"}, int'(FRAME), 0);
        check({tag, "_fv"},    int'(FRAME_VALID), 0);
        check({tag, "_busy"},  int'(BUSY), 0);
    endtask

    // START is high during cycle 0; cycle c is observed just after edge c.
    task automatic run_scan(input scan_vec_t v);
        int   chs[$];
        int   k;
        logic got_frame;
        chs.delete();
        for (int i = 0; i < 4; i++) if (v.mask[i]) chs.push_back(i);
        k = 0;
        got_frame = 1'b0;
        mux_in = v.ins;
        CHANNEL_MASK = v.mask;
        START = 1'b1;
        for (int c = 1; c <= 40 && !got_frame; c++) begin
            step();
            START = 1'b0;
            if (c == 1) begin
                check("scan_busy_start", int'(BUSY), 1);
                check("scan_frame_clear", int'(FRAME), 0);
                check("scan_first_sel", int'({SELECTOR_1, SELECTOR_2}), chs[0]);
            end
            if (BUSY) check("scan_sel_enabled", int'(v.mask[{SELECTOR_1, SELECTOR_2}]), 1);
            if (SAMPLE_VALID) begin
                if (k < chs.size()) begin
                    check("scan_sv_cycle", c, 6 + 5 * k);
                    check("scan_sv_chan", int'(SAMPLE_CHANNEL), chs[k]);
                    check("scan_sv_bit", int'(SAMPLE_BIT), int'(v.ins[chs[k]]));
                end else begin
                    check("scan_sv_extra", 1, 0);
                end
                k++;
            end
            if (FRAME_VALID) begin
                got_frame = 1'b1;
                check("scan_fv_cycle", c, v.exp_last);
                check("scan_frame", int'(FRAME), int'(v.exp_frame));
                check("scan_busy_end", int'(BUSY), 0);
                check("scan_fv_with_sv", int'(SAMPLE_VALID), 1);
            end
        end
        if (!got_frame) check("scan_frame_timeout", 0, 1);
        check("scan_sample_count", k, chs.size());
        step();
        step();
    endtask

    // Only channel 1 enabled; MUX_OUT forced to 1 in IDLE and SETTLE to show it is ignored.
    task automatic run_vote(input vote_vec_t v);
        mux_in = 4'b0000;
        ovr_en = 1'b1;
        ovr_val = 1'b1;
        CHANNEL_MASK = 4'b0010;
        START = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            START = 1'b0;
            if (c >= 2 && c <= 5) ovr_val = v.pat[5 - c];
            if (c == 6) begin
                check("vote_sv", int'(SAMPLE_VALID), 1);
                check("vote_chan", int'(SAMPLE_CHANNEL), 1);
                check("vote_bit", int'(SAMPLE_BIT), int'(v.exp_bit));
                check("vote_frame", int'(FRAME), v.exp_bit ? 2 : 0);
            end
        end
        ovr_en = 1'b0;
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int activity;
        int exp_fv;

        scans[0] = '{4'b1111, 4'b1010, 4'b1010, 21};
        scans[1] = '{4'b0101, 4'b1111, 4'b0101, 11};
        scans[2] = '{4'b0110, 4'b0100, 4'b0100, 11};
        scans[3] = '{4'b1000, 4'b1000, 4'b1000, 6};
        scans[4] = '{4'b0011, 4'b1110, 4'b0010, 11};

        votes[0] = '{4'b1100, 1'b0};
        votes[1] = '{4'b1110, 1'b1};
        votes[2] = '{4'b0001, 1'b0};
        votes[3] = '{4'b1111, 1'b1};
        votes[4] = '{4'b0000, 1'b0};
        votes[5] = '{4'b0111, 1'b1};

        RST_N = 1'b0;
        START = 1'b0;
        CONTINUOUS = 1'b0;
        CHANNEL_MASK = 4'b0000;
        mux_in = 4'b0000;
        ovr_en = 1'b0;
        ovr_val = 1'b0;
        step();
        step();
        check_all_zero("reset");
        RST_N = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_scan(scans[i]);
        for (int i = 0; i < 6; i++) run_vote(votes[i]);

        // Continuous on channel 3; mask switches to channel 0 mid-frame, then run stops.
        mux_in = 4'b1001;
        CHANNEL_MASK = 4'b1000;
        CONTINUOUS = 1'b1;
        START = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            step();
            START = 1'b0;
            if (c == 8) CHANNEL_MASK = 4'b0001;
            if (c == 17) CONTINUOUS = 1'b0;
            exp_fv = (c == 6 || c == 11 || c == 16 || c == 21) ? 1 : 0;
            check("cont_fv", int'(FRAME_VALID), exp_fv);
            if (exp_fv == 1) begin
                check("cont_chan", int'(SAMPLE_CHANNEL), (c <= 11) ? 3 : 0);
                check("cont_frame", int'(FRAME), (c <= 11) ? 8 : 1);
                check("cont_busy_fv", int'(BUSY), (c == 21) ? 0 : 1);
            end
            if (c == 9)  check("cont_sel_hold", int'({SELECTOR_1, SELECTOR_2}), 3);
            if (c == 12) check("cont_sel_relatch", int'({SELECTOR_1, SELECTOR_2}), 0);
            if (c > 21)  check("cont_idle_busy", int'(BUSY), 0);
        end

        // Reset during channel 2 SETTLE discards the partial frame.
        mux_in = 4'b1111;
        CHANNEL_MASK = 4'b1111;
        START = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            START = 1'b0;
        end
        check("pre_reset_sel", int'({SELECTOR_1, SELECTOR_2}), 2);
        check("pre_reset_frame", int'(FRAME), 3);
        RST_N = 1'b0;
        step();
        check_all_zero("midreset");
        RST_N = 1'b1;
        step();

        // START with an all-zero mask does nothing.
        CHANNEL_MASK = 4'b0000;
        START = 1'b1;
        activity = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            START = 1'b0;
            if (BUSY || SAMPLE_VALID || FRAME_VALID) activity++;
        end
        check("zero_mask_activity", activity, 0);

        // A START pulse while busy is ignored.
        mux_in = 4'b0001;
        CHANNEL_MASK = 4'b0001;
        START = 1'b1;
        activity = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            START = (c == 3);
            if (c >= 3) CHANNEL_MASK = 4'b1111;
            if (c == 6) begin
                check("busy_start_fv", int'(FRAME_VALID), 1);
                check("busy_start_frame", int'(FRAME), 1);
                check("busy_start_chan", int'(SAMPLE_CHANNEL), 0);
                check("busy_start_busy", int'(BUSY), 0);
            end
            if (c > 6 && (BUSY || SAMPLE_VALID || FRAME_VALID)) activity++;
        end
        check("busy_start_activity", activity, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_channel_scanner.md
Name: mux_channel_scanner

Overview:
- Upstream sequencer for the 4-channel MUX. Drives SELECTOR_1/SELECTOR_2 through the enabled channels and waits a settle time after each switch.
- Samples the MUX output (OUTPUT_1) over a dwell window, majority-votes the samples and reports one bit per channel.
- Assembles a 4-bit frame per scan. Runs single-shot or continuous.

Parameters:
- SETTLE_CYCLES, 1, cycles after a selector change before sampling starts; legal range 1..255.
- DWELL_CYCLES, 4, samples taken per channel; legal range 1..255.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  one-cycle request to begin a scan; ignored unless the block is IDLE.
- CONTINUOUS  in  1  1 = restart the scan after each frame; sampled at each frame end.
- CHANNEL_MASK  in  4  bit i enables channel i; latched at START and at each continuous restart.
- MUX_OUT  in  1  connects to the MUX OUTPUT_1.
- SELECTOR_1  out  1  channel index MSB.
- SELECTOR_2  out  1  channel index LSB.
- SAMPLE_VALID  out  1  one-cycle pulse when a channel result is ready.
- SAMPLE_CHANNEL  out  2  channel index of the current result.
- SAMPLE_BIT  out  1  voted value for that channel.
- FRAME  out  4  bit i = voted value of channel i; disabled channels read 0.
- FRAME_VALID  out  1  one-cycle pulse when FRAME is complete.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Channel encoding is {SELECTOR_1, SELECTOR_2}: 00 = INPUT_1, 01 = INPUT_2, 10 = INPUT_3, 11 = INPUT_4. Channel index i maps to FRAME bit i.
- Reset (RST_N=0 at a clock edge):
  - All outputs go to 0 and the state goes to IDLE.
  - Counters and the latched mask clear.
  - This applies mid-scan as well: the partial frame is discarded.
- The state machine has three states: IDLE, SETTLE and SAMPLE.
- IDLE:
  - START=1 with a nonzero mask: latch the mask, clear FRAME, load the selectors with the lowest enabled index, go to SETTLE.
  - START=1 with an all-zero mask: no effect.
- SETTLE: stays for SETTLE_CYCLES cycles, then goes to SAMPLE. MUX_OUT is ignored.
- SAMPLE:
  - Stays for DWELL_CYCLES cycles and counts the cycles where MUX_OUT=1.
  - Vote: result = 1 iff 2*ones > DWELL_CYCLES. A tie resolves to 0.
- At the edge ending the last SAMPLE cycle:
  - SAMPLE_VALID=1, SAMPLE_CHANNEL=the current index, SAMPLE_BIT=the vote, FRAME[index]=the vote.
  - If a higher-index channel is enabled: the selectors move to the next enabled index and the state goes to SETTLE.
  - Otherwise the frame ends (next bullet).
- Frame end:
  - FRAME_VALID is asserted in the same cycle as the last SAMPLE_VALID.
  - If CONTINUOUS=1: re-latch the mask and go to SETTLE on the lowest enabled index. A re-latched zero mask goes to IDLE instead.
  - If CONTINUOUS=0: go to IDLE. BUSY is low from that same cycle.
- Timing:
  - Per-channel period is SETTLE_CYCLES + DWELL_CYCLES.
  - The first SAMPLE_VALID comes SETTLE_CYCLES + DWELL_CYCLES + 1 cycles after the START edge.
- Outputs:
  - SAMPLE_CHANNEL, SAMPLE_BIT and FRAME are registered and hold their last values until overwritten.
  - FRAME is stable while FRAME_VALID is high.
  - The selectors hold their last value in IDLE.
- Mid-operation rules:
  - Changes to CHANNEL_MASK mid-frame have no effect.
  - Deasserting CONTINUOUS mid-frame lets the current frame complete.
- Counter widths are $clog2(max(SETTLE_CYCLES, DWELL_CYCLES) + 1); there is no wrap within the legal range.

Decomposition:
- Shared package mux_scan_pkg:
  - state enum {IDLE, SETTLE, SAMPLE};
  - 2-bit channel index type;
  - selector encoding constants CH_IN1..CH_IN4;
  - function next_enabled(mask, idx) returning the found flag and the index.
- Sub-module mux_majority_sampler:
  - ones counter with clear/enable;
  - vote output parameterised by DWELL_CYCLES.
- The top level holds the FSM, selector registers and FRAME assembly.

Test Plan:
- Inputs 0,1,0,1; mask 1111; defaults; START pulse at cycle 0.
  - Selectors step 00,01,10,11.
  - SAMPLE_VALID at cycles 6, 11, 16, 21 with bits 0,1,0,1.
  - FRAME_VALID at cycle 21 with FRAME = 4'b1010; BUSY low from cycle 21.
- Mask 0101, inputs all 1.
  - Only channels 0 and 2 are visited; SELECTOR_1/SELECTOR_2 never take 01 or 11.
  - FRAME = 4'b0101.
- Vote: during channel 1 SAMPLE, MUX_OUT = 1,1,0,0 gives SAMPLE_BIT=0 (tie); MUX_OUT = 1,1,1,0 gives SAMPLE_BIT=1.
- CONTINUOUS=1 with mask 1000.
  - FRAME_VALID every 5 cycles.
  - Changing the mask to 0001 mid-frame takes effect only after the next FRAME_VALID.
  - CONTINUOUS=0 then ends the run after the current frame.
- RST_N=0 during channel 2 SETTLE: all outputs 0, state IDLE. START pulses while BUSY and START with mask 0000 produce no activity.
